// File: rtl/decode_if.sv
// Signal bundle between fetch/writeback and the decode stage.
// The master side drives the fetch slot and writeback port; the decode stage is the slave.
interface decode_if;
  logic        pipe_flush;
  logic        if_id__ins_misalign;
  logic [31:0] if_id__pc;
  logic [31:0] if_id__ins;
  logic        if_id__predict_taken;
  logic        wb_id__rd_we;
  logic [4:0]  wb_id__rd_index;
  logic [31:0] wb_id__rd_data;
  logic        data_hazard;
  logic        id_ex__valid;
  logic [31:0] id_ex__pc;
  logic [31:0] id_ex__rs1_data;
  logic [31:0] id_ex__rs2_data;
  logic [31:0] id_ex__imm;
  logic [4:0]  id_ex__rd_index;
  logic        id_ex__rd_we;
  logic [4:0]  id_ex__opcode;
  logic [2:0]  id_ex__funct3;
  logic        id_ex__funct7b5;
  logic        id_ex__mem_read;
  logic        id_ex__mem_write;
  logic        id_ex__predict_taken;
  logic        id_ex__trap;
  logic [3:0]  id_ex__trap_cause;
  logic [31:0] hazard_count;

  modport master (
    output pipe_flush, if_id__ins_misalign, if_id__pc, if_id__ins, if_id__predict_taken,
           wb_id__rd_we, wb_id__rd_index, wb_id__rd_data,
    input  data_hazard, id_ex__valid, id_ex__pc, id_ex__rs1_data, id_ex__rs2_data,
           id_ex__imm, id_ex__rd_index, id_ex__rd_we, id_ex__opcode, id_ex__funct3,
           id_ex__funct7b5, id_ex__mem_read, id_ex__mem_write, id_ex__predict_taken,
           id_ex__trap, id_ex__trap_cause, hazard_count
  );

  modport slave (
    input  pipe_flush, if_id__ins_misalign, if_id__pc, if_id__ins, if_id__predict_taken,
           wb_id__rd_we, wb_id__rd_index, wb_id__rd_data,
    output data_hazard, id_ex__valid, id_ex__pc, id_ex__rs1_data, id_ex__rs2_data,
           id_ex__imm, id_ex__rd_index, id_ex__rd_we, id_ex__opcode, id_ex__funct3,
           id_ex__funct7b5, id_ex__mem_read, id_ex__mem_write, id_ex__predict_taken,
           id_ex__trap, id_ex__trap_cause, hazard_count
  );
endinterface

// File: rtl/decode.sv
// RV32I decode stage: register file with write-before-read bypass, immediate
// generation, trap classification, load-use hazard detection and the id_ex register.
module decode (
  input  logic     clk,
  input  logic     rst,
  decode_if.slave  bus
);

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_MISC   = 5'b00011;
  localparam logic [4:0] OP_IMM    = 5'b00100;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_OP     = 5'b01100;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_SYSTEM = 5'b11100;

  logic [31:0] ins;
  logic [4:0]  op, rs1, rs2, rd;
  logic        legal, rs1_used, rs2_used, writes_rd;
  logic [31:0] imm;
  logic        trap, rd_we_dec, mem_read_dec, mem_write_dec;
  logic [3:0]  cause_dec;
  logic [31:0] rs1_data, rs2_data;
  logic [31:0] regs [32];

  assign ins = bus.if_id__ins;
  assign op  = ins[6:2];
  assign rs1 = ins[19:15];
  assign rs2 = ins[24:20];
  assign rd  = ins[11:7];

  // Classify the opcode: legality, which operands it reads, whether it writes rd, and its immediate.
  always_comb begin
    legal     = 1'b0;
    rs1_used  = 1'b0;
    rs2_used  = 1'b0;
    writes_rd = 1'b0;
    imm       = 32'd0;
    case (op)
      OP_LUI, OP_AUIPC: begin
        legal = 1'b1; writes_rd = 1'b1;
        imm = {ins[31:12], 12'b0};
      end
      OP_JAL: begin
        legal = 1'b1; writes_rd = 1'b1;
        imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      OP_JALR, OP_LOAD, OP_IMM: begin
        legal = 1'b1; rs1_used = 1'b1; writes_rd = 1'b1;
        imm = {{20{ins[31]}}, ins[31:20]};
      end
      OP_BRANCH: begin
        legal = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1;
        imm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      end
      OP_STORE: begin
        legal = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1;
        imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      end
      OP_OP: begin
        legal = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1; writes_rd = 1'b1;
      end
      OP_MISC, OP_SYSTEM: begin
        legal = 1'b1;
        imm = {{20{ins[31]}}, ins[31:20]};
      end
      default: ;
    endcase
    if (ins[1:0] != 2'b11) legal = 1'b0;
  end

  // A trapping instruction must not write rd or touch memory; misalignment outranks illegal.
  assign trap          = bus.if_id__ins_misalign | ~legal;
  assign cause_dec     = bus.if_id__ins_misalign ? 4'd0 : (legal ? 4'd0 : 4'd2);
  assign rd_we_dec     = writes_rd & (rd != 5'd0) & ~trap;
  assign mem_read_dec  = (op == OP_LOAD) & ~trap;
  assign mem_write_dec = (op == OP_STORE) & ~trap;

  // Register file write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (bus.wb_id__rd_we && bus.wb_id__rd_index != 5'd0)
      regs[bus.wb_id__rd_index] <= bus.wb_id__rd_data;
  end

  assign rs1_data = (rs1 == 5'd0) ? 32'd0 :
                    (bus.wb_id__rd_we && bus.wb_id__rd_index == rs1) ? bus.wb_id__rd_data : regs[rs1];
  assign rs2_data = (rs2 == 5'd0) ? 32'd0 :
                    (bus.wb_id__rd_we && bus.wb_id__rd_index == rs2) ? bus.wb_id__rd_data : regs[rs2];

  // Load-use stall: the load in id_ex cannot forward in time, so hold fetch for one cycle.
  assign bus.data_hazard = bus.id_ex__valid & bus.id_ex__mem_read & (bus.id_ex__rd_index != 5'd0) &
                           ~bus.pipe_flush &
                           ((rs1_used & (rs1 == bus.id_ex__rd_index)) |
                            (rs2_used & (rs2 == bus.id_ex__rd_index)));

  // Stall cycle counter, wraps naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (rst)                  bus.hazard_count <= 32'd0;
    else if (bus.data_hazard) bus.hazard_count <= bus.hazard_count + 32'd1;
  end

  // id_ex control fields: reset and bubbles (flush or stall) clear everything that has side effects.
  always_ff @(posedge clk) begin
    if (rst || bus.pipe_flush || bus.data_hazard) begin
      bus.id_ex__valid         <= 1'b0;
      bus.id_ex__rd_we         <= 1'b0;
      bus.id_ex__mem_read      <= 1'b0;
      bus.id_ex__mem_write     <= 1'b0;
      bus.id_ex__trap          <= 1'b0;
      bus.id_ex__trap_cause    <= 4'd0;
      bus.id_ex__predict_taken <= 1'b0;
    end else begin
      bus.id_ex__valid         <= 1'b1;
      bus.id_ex__rd_we         <= rd_we_dec;
      bus.id_ex__mem_read      <= mem_read_dec;
      bus.id_ex__mem_write     <= mem_write_dec;
      bus.id_ex__trap          <= trap;
      bus.id_ex__trap_cause    <= cause_dec;
      bus.id_ex__predict_taken <= bus.if_id__predict_taken;
    end
  end

  // id_ex datapath fields load every cycle; consumers qualify them with id_ex__valid.
  always_ff @(posedge clk) begin
    bus.id_ex__pc       <= bus.if_id__pc;
    bus.id_ex__rs1_data <= rs1_data;
    bus.id_ex__rs2_data <= rs2_data;
    bus.id_ex__imm      <= imm;
    bus.id_ex__rd_index <= rd;
    bus.id_ex__opcode   <= op;
    bus.id_ex__funct3   <= ins[14:12];
    bus.id_ex__funct7b5 <= ins[30];
  end

endmodule

// File: tb/tb_decode.sv
// Bench for the decode stage: reference model, hand-computed vector table,
// directed multi-cycle scenarios and randomized instruction streams.
module tb_decode;
  logic clk = 1'b0;
  logic rst = 1'b1;
  decode_if bus ();

  decode dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state: architectural registers and the instruction now in id_ex.
  logic [31:0] m_regs [32];
  bit          m_valid = 1'b0;
  bit          m_load  = 1'b0;
  logic [4:0]  m_rd    = 5'd0;
  logic [31:0] m_hc    = 32'd0;
  bit          last_hz = 1'b0;

  typedef struct {
    logic [31:0] imm;
    bit imm_chk, rd_we, mr, mw, trap, rs1u, rs2u;
    logic [3:0] cause;
  } dec_t;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] imm;
    bit imm_chk, rd_we, mr, mw, trap;
    logic [3:0] cause;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual %0h, required %0h", name, $time, act, exp);
    end
  endtask

  function automatic dec_t mdec(input logic [31:0] ins, input logic mis);
    dec_t d;
    int s;
    bit legal;
    logic [6:0] c;
    s = $signed(ins);
    c = ins[6:0];
    legal = c inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
    d.imm = 32'd0; d.imm_chk = legal;
    d.rs1u = legal && (c inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67});
    d.rs2u = legal && (c inside {7'h33, 7'h23, 7'h63});
    case (c)
      7'h13, 7'h03, 7'h67, 7'h0F, 7'h73: d.imm = s >>> 20;
      7'h23: d.imm = ((s >>> 25) <<< 5) | int'(ins[11:7]);
      7'h63: d.imm = ((s >>> 31) <<< 12) | (int'(ins[7]) << 11) | (int'(ins[30:25]) << 5) | (int'(ins[11:8]) << 1);
      7'h37, 7'h17: d.imm = ins & 32'hFFFFF000;
      7'h6F: d.imm = ((s >>> 31) <<< 20) | (int'(ins[19:12]) << 12) | (int'(ins[20]) << 11) | (int'(ins[30:21]) << 1);
      default: d.imm_chk = 1'b0;
    endcase
    d.trap  = mis || !legal;
    d.cause = mis ? 4'd0 : (legal ? 4'd0 : 4'd2);
    d.rd_we = !d.trap && (c inside {7'h33, 7'h13, 7'h03, 7'h37, 7'h17, 7'h6F, 7'h67}) && ins[11:7] != 5'd0;
    d.mr    = !d.trap && c == 7'h03;
    d.mw    = !d.trap && c == 7'h23;
    return d;
  endfunction

  // One cycle: drive at negedge, check the combinational hazard, advance the model, check id_ex after the edge.
  task automatic step(input logic r, input logic fl, input logic [31:0] ins, input logic [31:0] pc,
                      input logic mis, input logic pt,
                      input logic wwe, input logic [4:0] widx, input logic [31:0] wdata);
    dec_t d;
    bit hz, ev;
    logic [31:0] e1, e2;
    @(negedge clk);
    rst = r;
    bus.pipe_flush = fl;
    bus.if_id__ins = ins;
    bus.if_id__pc = pc;
    bus.if_id__ins_misalign = mis;
    bus.if_id__predict_taken = pt;
    bus.wb_id__rd_we = wwe;
    bus.wb_id__rd_index = widx;
    bus.wb_id__rd_data = wdata;
    #1;
    d  = mdec(ins, mis);
    hz = m_valid && m_load && m_rd != 5'd0 && !fl &&
         ((d.rs1u && ins[19:15] == m_rd) || (d.rs2u && ins[24:20] == m_rd));
    chk("data_hazard", {31'd0, bus.data_hazard}, {31'd0, hz});
    if (wwe && widx != 5'd0) m_regs[widx] = wdata;
    e1 = m_regs[ins[19:15]];
    e2 = m_regs[ins[24:20]];
    if (r) begin
      m_valid = 1'b0; m_load = 1'b0; m_hc = 32'd0;
    end else begin
      if (hz) m_hc = m_hc + 32'd1;
      if (fl || hz) begin
        m_valid = 1'b0; m_load = 1'b0;
      end else begin
        m_valid = 1'b1; m_load = d.mr; m_rd = ins[11:7];
      end
    end
    last_hz = hz;
    ev = m_valid;
    @(posedge clk);
    #1;
    chk("valid", {31'd0, bus.id_ex__valid}, {31'd0, ev});
    chk("hazard_count", bus.hazard_count, m_hc);
    chk("rd_we", {31'd0, bus.id_ex__rd_we}, {31'd0, ev && d.rd_we});
    chk("mem_read", {31'd0, bus.id_ex__mem_read}, {31'd0, ev && d.mr});
    chk("mem_write", {31'd0, bus.id_ex__mem_write}, {31'd0, ev && d.mw});
    chk("trap", {31'd0, bus.id_ex__trap}, {31'd0, ev && d.trap});
    chk("trap_cause", {28'd0, bus.id_ex__trap_cause}, ev ? {28'd0, d.cause} : 32'd0);
    chk("predict_taken", {31'd0, bus.id_ex__predict_taken}, {31'd0, ev && pt});
    if (ev) begin
      chk("pc", bus.id_ex__pc, pc);
      chk("rs1_data", bus.id_ex__rs1_data, e1);
      chk("rs2_data", bus.id_ex__rs2_data, e2);
      if (d.imm_chk) chk("imm", bus.id_ex__imm, d.imm);
      chk("rd_index", {27'd0, bus.id_ex__rd_index}, {27'd0, ins[11:7]});
      chk("opcode", {27'd0, bus.id_ex__opcode}, {27'd0, ins[6:2]});
      chk("funct3", {29'd0, bus.id_ex__funct3}, {29'd0, ins[14:12]});
      chk("funct7b5", {31'd0, bus.id_ex__funct7b5}, {31'd0, ins[30]});
    end
  endtask

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] LW7 = 32'h0000_A383;   // lw  x7,0(x1)
  localparam logic [31:0] ADD = 32'h0023_8433;   // add x8,x7,x2

  vec_t tbl [14];
  logic [6:0] codes [12];

  initial begin
    tbl[0]  = '{32'hFFF28313, 32'hFFFFFFFF, 1, 1, 0, 0, 0, 4'd0}; // addi x6,x5,-1
    tbl[1]  = '{32'h80000537, 32'h80000000, 1, 1, 0, 0, 0, 4'd0}; // lui x10
    tbl[2]  = '{32'h12345597, 32'h12345000, 1, 1, 0, 0, 0, 4'd0}; // auipc x11
    tbl[3]  = '{32'hFFDFF0EF, 32'hFFFFFFFC, 1, 1, 0, 0, 0, 4'd0}; // jal x1,-4
    tbl[4]  = '{32'hFE208CE3, 32'hFFFFFFF8, 1, 0, 0, 0, 0, 4'd0}; // beq x1,x2,-8
    tbl[5]  = '{32'hFFC12483, 32'hFFFFFFFC, 1, 1, 1, 0, 0, 4'd0}; // lw x9,-4(x2)
    tbl[6]  = '{32'h00322423, 32'h00000008, 1, 0, 0, 1, 0, 4'd0}; // sw x3,8(x4)
    tbl[7]  = '{32'hFE530FA3, 32'hFFFFFFFF, 1, 0, 0, 1, 0, 4'd0}; // sb x5,-1(x6)
    tbl[8]  = '{32'h00238433, 32'h00000000, 0, 1, 0, 0, 0, 4'd0}; // add x8,x7,x2
    tbl[9]  = '{32'h40208033, 32'h00000000, 0, 0, 0, 0, 0, 4'd0}; // sub x0,x1,x2
    tbl[10] = '{32'h00000000, 32'h00000000, 0, 0, 0, 0, 1, 4'd2}; // all-zero word
    tbl[11] = '{32'h0000007F, 32'h00000000, 0, 0, 0, 0, 1, 4'd2}; // unknown opcode
    tbl[12] = '{32'h00000073, 32'h00000000, 1, 0, 0, 0, 0, 4'd0}; // ecall
    tbl[13] = '{32'h0000000F, 32'h00000000, 1, 0, 0, 0, 0, 4'd0}; // fence
    codes = '{7'h03, 7'h03, 7'h03, 7'h33, 7'h33, 7'h13, 7'h23, 7'h63, 7'h67, 7'h37, 7'h6F, 7'h7F};

    bus.pipe_flush = 0; bus.if_id__ins = NOP; bus.if_id__pc = 0; bus.if_id__ins_misalign = 0;
    bus.if_id__predict_taken = 0; bus.wb_id__rd_we = 0; bus.wb_id__rd_index = 0; bus.wb_id__rd_data = 0;
    m_regs[0] = 32'd0;
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // Reset state, including an attempt to push control values in while held in reset.
    step(1, 0, ADD, 32'h100, 1, 1, 0, 0, 0);
    step(1, 0, LW7, 32'h104, 0, 1, 0, 0, 0);

    for (int i = 1; i < 32; i++) step(0, 0, NOP, 32'h200 + 4 * i, 0, 0, 1, 5'(i), $urandom);

    // Write then read across a cycle.
    step(0, 0, NOP, 32'h300, 0, 0, 1, 5'd5, 32'h12345678);
    step(0, 0, 32'hFFF28313, 32'h304, 0, 0, 0, 0, 0);
    chk("s019_rs1", bus.id_ex__rs1_data, 32'h12345678);
    chk("s019_imm", bus.id_ex__imm, 32'hFFFFFFFF);
    chk("s019_rd", {27'd0, bus.id_ex__rd_index}, 32'd6);

    // Table of hand-encoded instructions.
    foreach (tbl[i]) begin
      step(0, 0, tbl[i].ins, 32'h400 + 4 * i, 0, 0, 0, 0, 0);
      if (tbl[i].imm_chk) chk("tbl_imm", bus.id_ex__imm, tbl[i].imm);
      chk("tbl_ctl", {27'd0, bus.id_ex__rd_we, bus.id_ex__mem_read, bus.id_ex__mem_write,
                      bus.id_ex__trap, bus.id_ex__valid},
                     {27'd0, tbl[i].rd_we, tbl[i].mr, tbl[i].mw, tbl[i].trap, 1'b1});
      chk("tbl_cause", {28'd0, bus.id_ex__trap_cause}, {28'd0, tbl[i].cause});
    end

    // Load-use: one stall, one bubble, then the consumer issues.
    step(1, 0, NOP, 0, 0, 0, 0, 0, 0);
    step(0, 0, LW7, 32'h500, 0, 0, 0, 0, 0);
    step(0, 0, ADD, 32'h504, 0, 0, 0, 0, 0);
    chk("s020_bubble", {31'd0, bus.id_ex__valid}, 32'd0);
    chk("s020_count1", bus.hazard_count, 32'd1);
    step(0, 0, ADD, 32'h504, 0, 0, 0, 0, 0);
    chk("s020_issue", {31'd0, bus.id_ex__valid}, 32'd1);
    chk("s020_count2", bus.hazard_count, 32'd1);

    // Flush overrides a load-use pair.
    step(0, 0, LW7, 32'h508, 0, 0, 0, 0, 0);
    step(0, 1, ADD, 32'h50C, 0, 0, 0, 0, 0);
    chk("s021_valid", {31'd0, bus.id_ex__valid}, 32'd0);
    chk("s021_count", bus.hazard_count, 32'd1);

    // Traps: illegal word and misaligned fetch of a legal ADD.
    step(0, 0, 32'h0, 32'h510, 0, 0, 0, 0, 0);
    chk("s022_illegal", {27'd0, bus.id_ex__trap, bus.id_ex__trap_cause}, {27'd0, 1'b1, 4'd2});
    step(0, 0, ADD, 32'h512, 1, 0, 0, 0, 0);
    chk("s022_misalign", {27'd0, bus.id_ex__trap, bus.id_ex__trap_cause}, {27'd0, 1'b1, 4'd0});

    // Same-cycle writeback bypass into a store.
    step(0, 0, 32'h00322423, 32'h520, 0, 0, 1, 5'd3, 32'hDEADBEEF);
    chk("s023_rs2", bus.id_ex__rs2_data, 32'hDEADBEEF);
    chk("s023_ctl", {30'd0, bus.id_ex__mem_write, bus.id_ex__rd_we}, 32'd2);

    // Reset during a stall cycle clears the stall and the counter.
    step(0, 0, LW7, 32'h530, 0, 0, 0, 0, 0);
    step(1, 0, ADD, 32'h534, 0, 0, 0, 0, 0);
    chk("s024_count", bus.hazard_count, 32'd0);
    step(0, 0, ADD, 32'h534, 0, 0, 0, 0, 0);

    // Randomized stream; fetch holds its slot whenever the model predicts a stall.
    begin
      logic [31:0] ins, pc;
      logic mis, pt;
      ins = NOP; pc = 32'h1000; mis = 0; pt = 0;
      for (int n = 0; n < 500; n++) begin
        if (!last_hz) begin
          ins = $urandom;
          ins[6:0]   = codes[$urandom_range(0, 11)];
          ins[11:7]  = 5'($urandom_range(0, 7));
          ins[19:15] = 5'($urandom_range(0, 7));
          ins[24:20] = 5'($urandom_range(0, 7));
          pc  = pc + 4;
          mis = ($urandom_range(0, 19) == 0);
          pt  = 1'($urandom);
        end
        step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) == 0), ins, pc, mis, pt,
             1'($urandom), 5'($urandom_range(0, 7)), $urandom);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/decode.md
DECODE -- requirements
Module: decode

Interface
REQ-001 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- pipe_flush  in  1  the current if_id slot holds a wrong-path instruction.
- if_id__ins_misalign  in  1  the fetched PC was not word aligned.
- if_id__pc  in  32  PC of the fetched instruction.
- if_id__ins  in  32  fetched instruction word.
- if_id__predict_taken  in  1  fetch redirected on a static prediction.
- wb_id__rd_we  in  1  writeback register write enable.
- wb_id__rd_index  in  5  writeback destination register.
- wb_id__rd_data  in  32  writeback data.
- data_hazard  out  1  combinational; asserted means fetch holds its PC and if_id__pc.
- id_ex__valid  out  1  the id_ex slot holds a real instruction.
- id_ex__pc  out  32  PC carried forward.
- id_ex__rs1_data, id_ex__rs2_data  out  32 each  register operands.
- id_ex__imm  out  32  sign-extended immediate.
- id_ex__rd_index  out  5  destination register.
- id_ex__rd_we  out  1  the instruction writes rd.
- id_ex__opcode  out  5  bits ins[6:2].
- id_ex__funct3  out  3  bits ins[14:12].
- id_ex__funct7b5  out  1  bit ins[30].
- id_ex__mem_read, id_ex__mem_write  out  1 each  load or store.
- id_ex__predict_taken  out  1  carried forward.
- id_ex__trap  out  1  the instruction traps.
- id_ex__trap_cause  out  4  0 = instruction misaligned; 2 = illegal instruction.
- hazard_count  out  32  count of load-use stall cycles.

Function
REQ-002 The block SHALL contain a 32x32 register file with 2 read ports and 1 write port; a write occurs when wb_id__rd_we is high and wb_id__rd_index != 0.
REQ-003 A read of x0 SHALL return 0.
REQ-004 When a read index equals wb_id__rd_index and the write is enabled in the same cycle, the read SHALL return wb_id__rd_data (write-before-read bypass).
REQ-005 Decode SHALL cover RV32I formats R/I/S/B/U/J.
- imm: I = ins[31:20]; S = {ins[31:25], ins[11:7]}; B = {ins[31], ins[7], ins[30:25], ins[11:8], 0}; U = {ins[31:12], 12'b0}; J = {ins[31], ins[19:12], ins[20], ins[30:21], 0}.
- All immediates SHALL be sign-extended from ins[31].
REQ-006 rs1 is used by R/I/S/B/JALR; rs2 is used by R/S/B.
- rd_we SHALL be 1 for R/I/U/J/JALR/LOAD when rd != 0.
- rd_we SHALL be 0 otherwise.
REQ-007 The instruction SHALL be illegal when ins[1:0] != 2'b11 or the opcode is outside {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, MISC-MEM, SYSTEM}.
- Illegal sets trap=1, cause=2, rd_we=0, mem_read=0, mem_write=0.
REQ-008 When if_id__ins_misalign=1, the block SHALL set trap=1 and cause=0; this takes priority over the illegal cause.
REQ-009 data_hazard SHALL equal id_ex__valid & id_ex__mem_read & (id_ex__rd_index != 0) & !pipe_flush & ((rs1 used & rs1 == id_ex__rd_index) | (rs2 used & rs2 == id_ex__rd_index)).
REQ-010 At each clock edge, the id_ex registers SHALL load with a latency of 1 cycle, by priority:
- rst: id_ex__valid <= 0, with all control outputs (rd_we, mem_read, mem_write, trap, predict_taken) <= 0.
- pipe_flush: bubble; id_ex__valid <= 0 and control outputs <= 0.
- data_hazard: bubble, as for pipe_flush; fetch re-presents the same instruction next cycle.
- otherwise: load the decoded fields, with id_ex__valid <= 1.
REQ-011 The datapath fields (pc, rs*_data, imm, indices, opcode/funct) MAY update on bubble cycles; consumers qualify them with id_ex__valid.
REQ-012 A bubble SHALL never assert rd_we, mem_read, mem_write or trap.
REQ-013 hazard_count SHALL increment by 1 at each edge where data_hazard=1 and rst=0, wrapping from 0xFFFFFFFF to 0.
REQ-014 When pipe_flush and data_hazard could both apply, the flush SHALL win; data_hazard is forced to 0 by REQ-009.
REQ-015 Back-to-back load-use stalls SHALL be impossible: after one bubble, id_ex__mem_read=0, so data_hazard deasserts.

Reset
REQ-016 While rst=1, the block SHALL force id_ex__valid, rd_we, mem_read, mem_write, trap, trap_cause and predict_taken to 0, and hazard_count to 0.
REQ-017 The register file contents SHALL NOT be cleared by reset, apart from x0 reading 0.
REQ-018 A reset asserted mid-stall SHALL clear the stall; data_hazard is 0 in the first cycle after reset because id_ex__valid=0.

Verification
REQ-019 Scenario: write x5=0x12345678 via the wb port, then decode ADDI x6,x5,-1 (0xFFF28313) -> rs1_data=0x12345678, imm=0xFFFFFFFF, rd_index=6, rd_we=1, valid=1.
REQ-020 Scenario: LW x7,0(x1), then ADD x8,x7,x2 -> data_hazard=1 for exactly 1 cycle, one bubble (valid=0), then ADD issues; hazard_count=1.
REQ-021 Scenario: pipe_flush=1 while a load-use pair is present -> data_hazard=0, id_ex__valid=0, hazard_count unchanged.
REQ-022 Scenario: if_id__ins=0x00000000 -> trap=1, cause=2, rd_we=0; if_id__ins_misalign=1 with a valid ADD -> trap=1, cause=0.
REQ-023 Scenario: same-cycle wb write x3=0xDEADBEEF while decoding SW x3,8(x4) -> rs2_data=0xDEADBEEF, imm=8, mem_write=1, rd_we=0.
REQ-024 Scenario: assert rst during a stall cycle -> next cycle valid=0, hazard_count=0, data_hazard=0.
